// File: rtl/serv_rf_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : serv_rf_ram_arb
//  Description : Arbiter between the SERV register file and a host port that
//                share one 1R1W RAM with 1-cycle read latency. The RF side
//                always has priority and is never stalled. Host accesses use
//                an RF-free cycle, or abort with an error after TIMEOUT
//                busy cycles.
//                Optional feature macro: SERV_RF_RAM_ARB_HOST_WR_EN
//                (defined: host writes reach the RAM; undefined: host writes
//                are rejected with an error and the host never drives o_wen).
//  Revision    : 1.0 - initial release
// ============================================================================
module serv_rf_ram_arb #(
    parameter int width   = 32,
    parameter int aw      = 6,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // register file side
    input  logic [aw-1:0]    i_rf_waddr,
    input  logic [width-1:0] i_rf_wdata,
    input  logic             i_rf_wen,
    input  logic [aw-1:0]    i_rf_raddr,
    input  logic             i_rf_ren,
    output logic [width-1:0] o_rf_rdata,
    // host side
    input  logic             i_hst_req,
    input  logic             i_hst_we,
    input  logic [aw-1:0]    i_hst_addr,
    input  logic [width-1:0] i_hst_wdata,
    output logic [width-1:0] o_hst_rdata,
    output logic             o_hst_ack,
    output logic             o_hst_err,
    // RAM side
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata
);

    // Counter only has to reach TIMEOUT-1
    localparam int            CW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_cnt_max = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RDLAT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_we;
    logic [aw-1:0]     r_addr;
    logic [width-1:0]  r_rdata;
    logic              w_latch;
    logic              w_cap;
    logic              w_hst_wen;
    logic              w_hst_ren;
    logic              w_busy;

    // The RAM port the pending host access needs is occupied by the RF
    assign w_busy = r_we ? i_rf_wen : i_rf_ren;

    // Next-state, counter/error update and host strobe generation
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        w_cap       = 1'b0;
        w_hst_wen   = 1'b0;
        w_hst_ren   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_hst_req) begin
                    w_latch   = 1'b1;
                    w_cnt_nxt = '0;
`ifdef SERV_RF_RAM_ARB_HOST_WR_EN
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_WAIT;
`else
                    // Host writes are not supported in this build
                    if (i_hst_we) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_WAIT;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (!w_busy) begin
                    if (r_we) begin
`ifdef SERV_RF_RAM_ARB_HOST_WR_EN
                        w_hst_wen   = 1'b1;
                        w_err_nxt   = 1'b0;
`else
                        // Unreachable: writes never enter WAIT in this build
                        w_err_nxt   = 1'b1;
`endif
                        w_state_nxt = S_DONE;
                    end else begin
                        w_hst_ren   = 1'b1;
                        w_state_nxt = S_RDLAT;
                    end
                end else if (r_cnt == c_cnt_max) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RDLAT: begin
                w_cap       = 1'b1;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout counter, error flag and host read data
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
            if (w_cap) begin
                r_rdata <= i_rdata;
            end
        end
    end

`ifdef SERV_RF_RAM_ARB_HOST_WR_EN
    logic [width-1:0] r_wdata;

    // Latched host request fields (no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_latch) begin
            r_we    <= i_hst_we;
            r_addr  <= i_hst_addr;
            r_wdata <= i_hst_wdata;
        end
    end

    assign o_wdata = w_hst_wen ? r_wdata : i_rf_wdata;
`else
    logic w_unused_wdata;
    assign w_unused_wdata = ^i_hst_wdata;

    // Latched host request fields (no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_latch) begin
            r_we   <= i_hst_we;
            r_addr <= i_hst_addr;
        end
    end

    assign o_wdata = i_rf_wdata;
`endif

    // RAM port muxing: host only ever drives a port the RF leaves idle
    assign o_wen   = i_rf_wen | w_hst_wen;
    assign o_waddr = w_hst_wen ? r_addr : i_rf_waddr;
    assign o_ren   = i_rf_ren | w_hst_ren;
    assign o_raddr = w_hst_ren ? r_addr : i_rf_raddr;

    assign o_rf_rdata  = i_rdata;
    assign o_hst_rdata = r_rdata;
    assign o_hst_ack   = (r_state == S_DONE);
    assign o_hst_err   = (r_state == S_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_ram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serv_rf_ram_arb
//  Description : Self-checking bench for serv_rf_ram_arb. A main instance
//                (TIMEOUT=64) and a short-timeout instance (TIMEOUT=4) share
//                all inputs; a behavioural 1R1W RAM serves the main instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_rf_ram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rf_waddr, rf_raddr, hst_addr;
    logic [31:0] rf_wdata, hst_wdata;
    logic        rf_wen, rf_ren, hst_req, hst_we;
    logic [31:0] rf_rdata, hst_rdata, wdata;
    logic        hst_ack, hst_err, wen, ren;
    logic [5:0]  waddr, raddr;
    logic [31:0] rf_rdata4, hst_rdata4, wdata4;
    logic        hst_ack4, hst_err4, wen4, ren4;
    logic [5:0]  waddr4, raddr4;
    logic [31:0] ram_q, ovr_rdata, rdata_mux;
    logic        use_ovr;
    logic [31:0] mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rdata_mux = use_ovr ? ovr_rdata : ram_q;

    // Behavioural RAM: 1-cycle read latency, read-before-write
    always @(posedge clk) begin
        if (ren) ram_q <= mem[raddr];
        if (wen) mem[waddr] <= wdata;
    end

    serv_rf_ram_arb #(.width(32), .aw(6), .TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata), .i_rf_wen(rf_wen),
        .i_rf_raddr(rf_raddr), .i_rf_ren(rf_ren), .o_rf_rdata(rf_rdata),
        .i_hst_req(hst_req), .i_hst_we(hst_we), .i_hst_addr(hst_addr),
        .i_hst_wdata(hst_wdata), .o_hst_rdata(hst_rdata), .o_hst_ack(hst_ack),
        .o_hst_err(hst_err),
        .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
        .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata_mux)
    );

    serv_rf_ram_arb #(.width(32), .aw(6), .TIMEOUT(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata), .i_rf_wen(rf_wen),
        .i_rf_raddr(rf_raddr), .i_rf_ren(rf_ren), .o_rf_rdata(rf_rdata4),
        .i_hst_req(hst_req), .i_hst_we(hst_we), .i_hst_addr(hst_addr),
        .i_hst_wdata(hst_wdata), .o_hst_rdata(hst_rdata4), .o_hst_ack(hst_ack4),
        .o_hst_err(hst_err4),
        .o_waddr(waddr4), .o_wdata(wdata4), .o_wen(wen4),
        .o_raddr(raddr4), .o_ren(ren4), .i_rdata(rdata_mux)
    );

    typedef struct {
        logic        wen;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic        ren;
        logic [5:0]  raddr;
        logic [31:0] rdata;
        logic        e_wen;
        logic        e_ren;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,        1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 6'd1,  32'h11111111, 1'b0, 6'd0,  32'hA5A5A5A5, 1'b1, 1'b0, 32'hA5A5A5A5};
        vecs[2] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd2,  32'h5A5A5A5A, 1'b0, 1'b1, 32'h5A5A5A5A};
        vecs[3] = '{1'b1, 6'd63, 32'hFFFFFFFF, 1'b1, 6'd63, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 6'd0,  32'h0,        1'b1, 6'd31, 32'h80000001, 1'b1, 1'b1, 32'h80000001};
        vecs[5] = '{1'b0, 6'd17, 32'hCAFEF00D, 1'b0, 6'd18, 32'h00000007, 1'b0, 1'b0, 32'h00000007};

        rst = 1'b1; use_ovr = 1'b0; ovr_rdata = '0;
        rf_waddr = '0; rf_wdata = '0; rf_wen = 1'b0; rf_raddr = '0; rf_ren = 1'b0;
        hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_wdata = '0;
        #1;
        // Reset state
        chk("reset_ack", hst_ack, 0);
        chk("reset_err", hst_err, 0);
        chk("reset_rdata", hst_rdata, 0);
        chk("reset_wen", wen, 0);
        chk("reset_ren", ren, 0);
        step(); step();
        rst = 1'b0;

        // RF pass-through table with host idle
        use_ovr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rf_wen = vecs[i].wen; rf_waddr = vecs[i].waddr; rf_wdata = vecs[i].wdata;
            rf_ren = vecs[i].ren; rf_raddr = vecs[i].raddr; ovr_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("tbl%0d_wen", i), wen, vecs[i].e_wen);
            chk($sformatf("tbl%0d_ren", i), ren, vecs[i].e_ren);
            chk($sformatf("tbl%0d_rfrdata", i), rf_rdata, vecs[i].e_rdata);
            if (vecs[i].e_wen) begin
                chk($sformatf("tbl%0d_waddr", i), waddr, vecs[i].waddr);
                chk($sformatf("tbl%0d_wdata", i), wdata, vecs[i].wdata);
            end
            if (vecs[i].e_ren)
                chk($sformatf("tbl%0d_raddr", i), raddr, vecs[i].raddr);
            step();
        end
        use_ovr = 1'b0;
        rf_wen = 1'b0; rf_ren = 1'b0;
        step();

        // Host write to address 5
        hst_req = 1'b1; hst_we = 1'b1; hst_addr = 6'd5; hst_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_ack_reqcyc", hst_ack, 0);
        step();
        hst_req = 1'b0;
`ifdef SERV_RF_RAM_ARB_HOST_WR_EN
        @(negedge clk);
        chk("wr_wen", wen, 1);
        chk("wr_waddr", waddr, 6'd5);
        chk("wr_wdata", wdata, 32'hDEADBEEF);
        chk("wr_ack_early", hst_ack, 0);
        step();
        @(negedge clk);
        chk("wr_ack", hst_ack, 1);
        chk("wr_err", hst_err, 0);
        step();
`else
        @(negedge clk);
        chk("wr_ack", hst_ack, 1);
        chk("wr_err", hst_err, 1);
        chk("wr_no_wen", wen, 0);
        step();
        // Seed address 5 through the RF port instead
        rf_wen = 1'b1; rf_waddr = 6'd5; rf_wdata = 32'hDEADBEEF;
        step();
        rf_wen = 1'b0;
`endif
        @(negedge clk);
        chk("wr_ack_one_cycle", hst_ack, 0);
        step();

        // Host read of address 5
        hst_req = 1'b1; hst_we = 1'b0; hst_addr = 6'd5;
        step();
        hst_req = 1'b0;
        @(negedge clk);
        chk("rd_ren", ren, 1);
        chk("rd_raddr", raddr, 6'd5);
        chk("rd_ack_p1", hst_ack, 0);
        step();
        @(negedge clk);
        chk("rd_ack_p2", hst_ack, 0);
        step();
        @(negedge clk);
        chk("rd_ack", hst_ack, 1);
        chk("rd_err", hst_err, 0);
        chk("rd_data", hst_rdata, 32'hDEADBEEF);
        step();

        // Seed address 9, then host read while RF reads for 10 cycles
        rf_wen = 1'b1; rf_waddr = 6'd9; rf_wdata = 32'h12345678;
        step();
        rf_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rf_ren = 1'b1; rf_raddr = 6'(20 + i);
            hst_req = (i == 0); hst_we = 1'b0; hst_addr = 6'd9;
            @(negedge clk);
            chk($sformatf("busy%0d_ren", i), ren, 1);
            chk($sformatf("busy%0d_raddr", i), raddr, 6'(20 + i));
            chk($sformatf("busy%0d_ack", i), hst_ack, 0);
            chk($sformatf("busy%0d_raddr4", i), raddr4, 6'(20 + i));
            chk($sformatf("busy%0d_ack4", i), hst_ack4, (i == 5));
            chk($sformatf("busy%0d_err4", i), hst_err4, (i == 5));
            step();
        end
        hst_req = 1'b0; rf_ren = 1'b0;
        @(negedge clk);
        chk("free_ren", ren, 1);
        chk("free_raddr", raddr, 6'd9);
        step();
        @(negedge clk);
        chk("free_ack_rdlat", hst_ack, 0);
        step();
        @(negedge clk);
        chk("free_ack", hst_ack, 1);
        chk("free_err", hst_err, 0);
        chk("free_data", hst_rdata, 32'h12345678);
        step();

`ifdef SERV_RF_RAM_ARB_HOST_WR_EN
        // Host write while RF writes continuously; short-timeout instance aborts
        for (int i = 0; i < 8; i++) begin
            rf_wen = 1'b1; rf_waddr = 6'd3; rf_wdata = 32'h33;
            hst_req = (i == 0); hst_we = 1'b1; hst_addr = 6'd7; hst_wdata = 32'h77;
            @(negedge clk);
            chk($sformatf("wbusy%0d_waddr", i), waddr, 6'd3);
            chk($sformatf("wbusy%0d_waddr4", i), waddr4, 6'd3);
            chk($sformatf("wbusy%0d_wdata4", i), wdata4, 32'h33);
            chk($sformatf("wbusy%0d_ack4", i), hst_ack4, (i == 5));
            chk($sformatf("wbusy%0d_err4", i), hst_err4, (i == 5));
            step();
        end
        hst_req = 1'b0; rf_wen = 1'b0;
        @(negedge clk);
        chk("wfree_wen", wen, 1);
        chk("wfree_waddr", waddr, 6'd7);
        chk("wfree_wdata", wdata, 32'h77);
        chk("wfree_no_wen4", wen4, 0);
        step();
        @(negedge clk);
        chk("wfree_ack", hst_ack, 1);
        chk("wfree_err", hst_err, 0);
        step();
`endif

        // Reset asserted during RDLAT abandons the read
        hst_req = 1'b1; hst_we = 1'b0; hst_addr = 6'd5;
        step();
        hst_req = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ack", hst_ack, 0);
        chk("rst_rdata", hst_rdata, 0);
        chk("rst_ren", ren, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst_noack%0d", i), hst_ack, 0);
            step();
        end

        // Next request after reset completes normally
        hst_req = 1'b1; hst_we = 1'b0; hst_addr = 6'd9;
        step();
        hst_req = 1'b0;
        @(negedge clk);
        chk("post_ren", ren, 1);
        step(); step();
        @(negedge clk);
        chk("post_ack", hst_ack, 1);
        chk("post_data", hst_rdata, 32'h12345678);
        step();

        // A write never alters the held read data
        hst_req = 1'b1; hst_we = 1'b1; hst_addr = 6'd10; hst_wdata = 32'hAB;
        step();
        hst_req = 1'b0;
`ifdef SERV_RF_RAM_ARB_HOST_WR_EN
        step();
        @(negedge clk);
        chk("last_ack", hst_ack, 1);
        chk("last_err", hst_err, 0);
`else
        @(negedge clk);
        chk("last_ack", hst_ack, 1);
        chk("last_err", hst_err, 1);
`endif
        chk("last_rdata_held", hst_rdata, 32'h12345678);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
